// File: rtl/ipu_pkg.sv
// Shared op-code definitions for the pixel processing pipeline and its per-lane ALU.
package ipu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
  localparam logic [OP_W-1:0] OP_MUL     = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB     = 3'b010;
  localparam logic [OP_W-1:0] OP_AVG     = 3'b011;
  localparam logic [OP_W-1:0] OP_MAX     = 3'b100;
  localparam logic [OP_W-1:0] OP_MIN     = 3'b101;
  localparam logic [OP_W-1:0] OP_ABSDIFF = 3'b110;
  localparam logic [OP_W-1:0] OP_THRESH  = 3'b111;

endpackage : ipu_pkg

// File: rtl/pixel_alu.sv
// Single-lane combinational pixel ALU (unsigned). Define SATURATE_EN to clamp ADD/SUB/MUL
// instead of wrapping modulo 2^DATA_W.
module pixel_alu
  import ipu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              a_ge_b;
`ifdef SATURATE_EN
  logic [2*DATA_W-1:0] prod;
`else
  logic [DATA_W-1:0]   prod;
`endif

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    // A borrow out of the extended subtraction means a < b.
    a_ge_b = ~diff[DATA_W];
`ifdef SATURATE_EN
    prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`else
    prod   = a * b;
`endif
  end

  always_comb begin
    // NOTE: every path assigns y (default first), so no latch is inferred.
    y = '0;
    case (op)
`ifdef SATURATE_EN
      OP_ADD:  y = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      OP_MUL:  y = (|prod[2*DATA_W-1:DATA_W]) ? '1 : prod[DATA_W-1:0];
      OP_SUB:  y = a_ge_b ? diff[DATA_W-1:0] : '0;
`else
      OP_ADD:  y = sum[DATA_W-1:0];
      OP_MUL:  y = prod;
      OP_SUB:  y = diff[DATA_W-1:0];
`endif
      OP_AVG:     y = sum[DATA_W:1];
      OP_MAX:     y = a_ge_b ? a : b;
      OP_MIN:     y = a_ge_b ? b : a;
      OP_ABSDIFF: y = a_ge_b ? diff[DATA_W-1:0] : (b - a);
      OP_THRESH:  y = a_ge_b ? '1 : '0;
      default:    y = '0;
    endcase
  end

endmodule : pixel_alu

// File: rtl/pixel_proc_pipe.sv
// Two-stage valid/ready pixel pipeline: CHANNELS independent ALU lanes plus a frame pixel
// counter driving Eof. SATURATE_EN (in pixel_alu) selects clamping arithmetic.
module pixel_proc_pipe
  import ipu_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 1,
  parameter int FRAME_PIXELS = 65536
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Load,
  output logic                         Ready,
  input  logic [CHANNELS*DATA_W-1:0]   A,
  input  logic [CHANNELS*DATA_W-1:0]   B,
  input  logic [OP_W-1:0]              opSel,
  output logic [CHANNELS*DATA_W-1:0]   C,
  output logic                         C_valid,
  input  logic                         C_ready,
  output logic                         Eof
);

  localparam int               BUS_W    = CHANNELS * DATA_W;
  localparam int               CNT_W    = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic             s1_valid_q, s1_valid_d;
  logic [BUS_W-1:0] s1_a_q, s1_a_d;
  logic [BUS_W-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [BUS_W-1:0] c_q, c_d;
  logic             c_valid_q, c_valid_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [BUS_W-1:0] alu_y;
  logic             s1_adv, s2_adv, out_xfer;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pixel_alu #(.DATA_W(DATA_W)) u_alu (
      .a  (s1_a_q[k*DATA_W +: DATA_W]),
      .b  (s1_b_q[k*DATA_W +: DATA_W]),
      .op (s1_op_q),
      .y  (alu_y[k*DATA_W +: DATA_W])
    );
  end

  // Each stage advances when its successor is empty or draining this cycle.
  assign s2_adv   = !c_valid_q || C_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_xfer = c_valid_q && C_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    c_d        = c_q;
    c_valid_d  = c_valid_q;
    pix_cnt_d  = pix_cnt_q;

    if (s1_adv) begin
      s1_valid_d = Load;
      if (Load) begin
        s1_a_d  = A;
        s1_b_d  = B;
        s1_op_d = opSel;
      end
    end

    if (s2_adv) begin
      c_valid_d = s1_valid_q;
      if (s1_valid_q) c_d = alu_y;
    end

    if (out_xfer) pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + CNT_W'(1);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid_q <= 1'b0;
      c_valid_q  <= 1'b0;
      c_q        <= '0;
      pix_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      c_valid_q  <= c_valid_d;
      c_q        <= c_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

  // NOTE: stage-1 payload has no reset; it is only consumed while s1_valid_q is set.
  always_ff @(posedge Clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
  end

  assign Ready   = s1_adv;
  assign C       = c_q;
  assign C_valid = c_valid_q;
  assign Eof     = c_valid_q && (pix_cnt_q == LAST_PIX);

endmodule : pixel_proc_pipe
